multihot_to_bin_seq: RTL and testbench
======================================

// Module: multihot_to_bin_seq
// PURPOSE
//  Registered, parametrised set-bit-to-index encoder with valid/ready on both sides.
//  STRICT mode (MODE=0): one index per input vector (LSB priority), plus error/zero flags.
//  DRAIN mode (MODE=1): emits the index of every set bit, LSB-first, one beat per set bit; last beat flagged.
//  Sits between request/flag vectors (IRQ lines, grant masks) and index-consuming logic.
// PARAMETERS
//  WIDTH  16              input vector width, >=2
//  IDX_W  $clog2(WIDTH)   index width; derived, do not override
//  MODE   0               0 = STRICT, 1 = DRAIN
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      asynchronous, active-high reset
//  in_vec     in   WIDTH  input vector
//  in_valid   in   1      in_vec valid
//  in_ready   out  1      block can accept in_vec this cycle
//  out_idx    out  IDX_W  bit index of the current beat
//  out_valid  out  1      out_* valid
//  out_ready  in   1      downstream accepts the beat
//  out_last   out  1      final beat of the current vector
//  out_zero   out  1      accepted vector was all zeros
//  out_err    out  1      STRICT only: popcount(in_vec)>1; tied 0 in DRAIN
//  err_cnt    out  16     only when ONEHOT_ERR_CNT_EN is defined
// BEHAVIOUR
//  - Reset (async, any state): out_valid=0, out_idx=0, out_last=0, out_zero=0, out_err=0,
//    pending mask=0, err_cnt=0, state IDLE. An in-flight vector is dropped, with no partial beats afterwards.
//  - Handshakes: input transfer on in_valid&&in_ready; output transfer on out_valid&&out_ready.
//  - in_ready = !out_valid || (out_ready && out_last). Combinational, so back-to-back vectors need no bubble.
//  - Latency: first beat is registered. out_valid rises the cycle after the input transfer.
//  - Once out_valid=1, out_* hold stable until the output transfer. No retraction.
//  - FSM: IDLE (out_valid=0) and EMIT (out_valid=1).
//    - IDLE -> EMIT on input transfer.
//    - EMIT -> EMIT on output transfer of a non-last beat, or on a last beat with a simultaneous input transfer.
//    - EMIT -> IDLE on output transfer of a last beat with no new input.
//  - On input transfer:
//    - out_idx = lowest set bit of in_vec.
//    - pend = in_vec with that bit cleared.
//    - out_zero = (in_vec==0); a zero vector gives out_idx=0.
//    - STRICT: out_last=1, pend is forced to 0, out_err = popcount>1.
//    - DRAIN: out_last = (pend==0).
//  - On output transfer of a non-last beat (DRAIN only): out_idx = lowest set bit of pend, clear that bit,
//    out_last = (new pend==0).
//  - Zero vector, either mode: exactly one beat, out_idx=0, out_zero=1, out_last=1.
//  - Bit WIDTH-1 set alone: out_idx=WIDTH-1, with no wrap or truncation.
// CONFIGURATION
//  - ONEHOT_ERR_CNT_EN defined:
//    - err_cnt port exists.
//    - It increments on every output transfer with out_err=1 and on every output transfer with out_zero=1.
//    - It saturates at 16'hFFFF. Async reset clears it.
//  - ONEHOT_ERR_CNT_EN undefined: the err_cnt port and counter logic are absent. All other behaviour is identical.
// STRUCTURE
//  - Package onehot_pkg: state typedef (IDLE, EMIT), MODE_STRICT=0 / MODE_DRAIN=1 constants,
//    ERR_CNT_W=16 constant.
//  - Sub-module lsb_prio_enc #(WIDTH): combinational find-first-set.
//    Outputs idx[IDX_W] and the one-hot lowest-bit mask.
//    Instantiated twice: once on in_vec, once on pend.
// TESTING
//  1. STRICT, in_vec=16'h0400 accepted, out_ready=1
//     -> next cycle out_valid=1, out_idx=10, out_last=1, out_err=0, out_zero=0.
//  2. STRICT, in_vec=16'h8010 -> out_idx=4, out_err=1.
//     With ONEHOT_ERR_CNT_EN: err_cnt goes 0->1 on the transfer.
//  3. DRAIN, in_vec=16'h8025, out_ready=1
//     -> 4 consecutive beats idx 0,2,5,15; out_last only on idx 15; in_ready=1 during that beat.
//  4. DRAIN, in_vec=16'h0003, out_ready held low 3 cycles
//     -> out_idx stays 0, out_valid stays 1, in_ready=0; release gives beats 0 then 1.
//  5. Back-to-back zero vectors, in_valid=1, out_ready=1 for 3 vectors
//     -> 3 beats on consecutive cycles, each out_idx=0, out_zero=1, out_last=1.
//  6. DRAIN, 16'hFFFF accepted; assert rst asynchronously after beat 3
//     -> out_valid=0 immediately, no further beats; next vector 16'h0100 gives a single beat idx 8.

Source files
------------

// File: rtl/onehot_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : onehot_pkg
// Brief    : Shared types and constants for the set-bit-to-index encoder.
// Revision : 1.0 - initial release
// ============================================================================
package onehot_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    localparam int MODE_STRICT = 0;
    localparam int MODE_DRAIN  = 1;
    localparam int ERR_CNT_W   = 16;

endpackage : onehot_pkg
`default_nettype wire

// File: rtl/lsb_prio_enc.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : lsb_prio_enc
// Brief    : Combinational find-first-set: index and one-hot mask of lowest set bit.
// Revision : 1.0 - initial release
// ============================================================================
module lsb_prio_enc #(
    parameter int WIDTH = 16,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] vec,
    output logic [IDX_W-1:0] idx,
    output logic [WIDTH-1:0] mask
);

    // Scan from the top so the lowest set bit is the last (winning) write.
    always_comb begin
        idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

    assign mask = vec & (~vec + WIDTH'(1));

endmodule : lsb_prio_enc
`default_nettype wire

// File: rtl/multihot_to_bin_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : multihot_to_bin_seq
// Brief    : Registered set-bit-to-index encoder, valid/ready both sides.
//            MODE 0 = STRICT (one beat, err/zero flags), 1 = DRAIN (beat per bit).
//            Define ONEHOT_ERR_CNT_EN to add the saturating err_cnt output.
// Revision : 1.0 - initial release
// ============================================================================
module multihot_to_bin_seq
    import onehot_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int IDX_W = $clog2(WIDTH),
    parameter int MODE  = MODE_STRICT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     in_vec,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [IDX_W-1:0]     out_idx,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last,
    output logic                 out_zero,
    output logic                 out_err
`ifdef ONEHOT_ERR_CNT_EN
    ,
    output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

    state_t             state_q,    state_d;
    logic [IDX_W-1:0]   out_idx_q,  out_idx_d;
    logic               out_last_q, out_last_d;
    logic               out_zero_q, out_zero_d;
    logic               out_err_q,  out_err_d;
    logic [WIDTH-1:0]   pend_q,     pend_d;

    logic [IDX_W-1:0]   w_in_idx;
    logic [WIDTH-1:0]   w_in_mask;
    logic [IDX_W-1:0]   w_pend_idx;
    logic [WIDTH-1:0]   w_pend_mask;
    logic [WIDTH-1:0]   w_in_rest;
    logic [WIDTH-1:0]   w_pend_rest;
    logic               w_in_xfer;
    logic               w_out_xfer;

    lsb_prio_enc #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_enc_in (
        .vec  (in_vec),
        .idx  (w_in_idx),
        .mask (w_in_mask)
    );

    lsb_prio_enc #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_enc_pend (
        .vec  (pend_q),
        .idx  (w_pend_idx),
        .mask (w_pend_mask)
    );

    assign w_in_rest   = in_vec & ~w_in_mask;
    assign w_pend_rest = pend_q & ~w_pend_mask;

    // Accepting during the last beat's transfer lets vectors stream without a bubble.
    assign out_valid  = (state_q == EMIT);
    assign in_ready   = !out_valid || (out_ready && out_last_q);
    assign w_in_xfer  = in_valid && in_ready;
    assign w_out_xfer = out_valid && out_ready;

    always_comb begin
        state_d    = state_q;
        out_idx_d  = out_idx_q;
        out_last_d = out_last_q;
        out_zero_d = out_zero_q;
        out_err_d  = out_err_q;
        pend_d     = pend_q;
        if (w_in_xfer) begin
            state_d    = EMIT;
            out_idx_d  = w_in_idx;
            out_zero_d = (in_vec == '0);
            if (MODE == MODE_DRAIN) begin
                pend_d     = w_in_rest;
                out_last_d = (w_in_rest == '0);
                out_err_d  = 1'b0;
            end else begin
                pend_d     = '0;
                out_last_d = 1'b1;
                out_err_d  = (w_in_rest != '0);
            end
        end else if (w_out_xfer) begin
            if (!out_last_q) begin
                out_idx_d  = w_pend_idx;
                pend_d     = w_pend_rest;
                out_last_d = (w_pend_rest == '0);
            end else begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            out_idx_q  <= '0;
            out_last_q <= 1'b0;
            out_zero_q <= 1'b0;
            out_err_q  <= 1'b0;
            pend_q     <= '0;
        end else begin
            state_q    <= state_d;
            out_idx_q  <= out_idx_d;
            out_last_q <= out_last_d;
            out_zero_q <= out_zero_d;
            out_err_q  <= out_err_d;
            pend_q     <= pend_d;
        end
    end

    assign out_idx  = out_idx_q;
    assign out_last = out_last_q;
    assign out_zero = out_zero_q;
    assign out_err  = out_err_q;

`ifdef ONEHOT_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    // A beat never carries both flags, so one increment per transfer suffices.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (w_out_xfer && (out_err_q || out_zero_q) && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule : multihot_to_bin_seq
`default_nettype wire

// File: tb/tb_multihot_to_bin_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_multihot_to_bin_seq
// Brief    : Scoreboard bench driving a STRICT and a DRAIN instance side by side.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multihot_to_bin_seq;

    typedef struct packed {
        logic [3:0] idx;
        logic       last;
        logic       zero;
        logic       err;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [15:0] s_in_vec = '0;
    logic        s_in_valid = 1'b0;
    logic        s_in_ready;
    logic [3:0]  s_out_idx;
    logic        s_out_valid;
    logic        s_out_ready = 1'b1;
    logic        s_out_last, s_out_zero, s_out_err;

    logic [15:0] d_in_vec = '0;
    logic        d_in_valid = 1'b0;
    logic        d_in_ready;
    logic [3:0]  d_out_idx;
    logic        d_out_valid;
    logic        d_out_ready = 1'b1;
    logic        d_out_last, d_out_zero, d_out_err;

`ifdef ONEHOT_ERR_CNT_EN
    logic [15:0] s_err_cnt, d_err_cnt;
`endif

    int    tests = 0;
    int    fails = 0;
    beat_t s_q[$];
    beat_t d_q[$];
    beat_t e_s, e_d;
    time   t0;

    always #5 clk = ~clk;

    multihot_to_bin_seq #(.WIDTH(16), .MODE(0)) u_strict (
        .clk       (clk),
        .rst       (rst),
        .in_vec    (s_in_vec),
        .in_valid  (s_in_valid),
        .in_ready  (s_in_ready),
        .out_idx   (s_out_idx),
        .out_valid (s_out_valid),
        .out_ready (s_out_ready),
        .out_last  (s_out_last),
        .out_zero  (s_out_zero),
        .out_err   (s_out_err)
`ifdef ONEHOT_ERR_CNT_EN
        ,
        .err_cnt   (s_err_cnt)
`endif
    );

    multihot_to_bin_seq #(.WIDTH(16), .MODE(1)) u_drain (
        .clk       (clk),
        .rst       (rst),
        .in_vec    (d_in_vec),
        .in_valid  (d_in_valid),
        .in_ready  (d_in_ready),
        .out_idx   (d_out_idx),
        .out_valid (d_out_valid),
        .out_ready (d_out_ready),
        .out_last  (d_out_last),
        .out_zero  (d_out_zero),
        .out_err   (d_out_err)
`ifdef ONEHOT_ERR_CNT_EN
        ,
        .err_cnt   (d_err_cnt)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_s(input logic [15:0] v);
        bit acc = 1'b0;
        s_in_vec   = v;
        s_in_valid = 1'b1;
        for (int c = 0; c < 50 && !acc; c++) begin
            @(negedge clk);
            acc = s_in_ready;
            @(posedge clk);
            #1;
        end
        s_in_valid = 1'b0;
        if (!acc) chk("strict_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_d(input logic [15:0] v);
        bit acc = 1'b0;
        d_in_vec   = v;
        d_in_valid = 1'b1;
        for (int c = 0; c < 50 && !acc; c++) begin
            @(negedge clk);
            acc = d_in_ready;
            @(posedge clk);
            #1;
        end
        d_in_valid = 1'b0;
        if (!acc) chk("drain_accept_timeout", 32'd0, 32'd1);
    endtask

    // Monitors: a beat is consumed at the next rising edge whenever valid&&ready here.
    always @(negedge clk) begin
        if (!rst && s_out_valid && s_out_ready) begin
            if (s_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL strict_unexpected_beat: got idx %0d, expected no beat", s_out_idx);
            end else begin
                e_s = s_q.pop_front();
                chk("strict_beat", {25'd0, s_out_idx, s_out_last, s_out_zero, s_out_err}, {25'd0, e_s});
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && d_out_valid && d_out_ready) begin
            if (d_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL drain_unexpected_beat: got idx %0d, expected no beat", d_out_idx);
            end else begin
                e_d = d_q.pop_front();
                chk("drain_beat", {25'd0, d_out_idx, d_out_last, d_out_zero, d_out_err}, {25'd0, e_d});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_strict", {s_out_valid, s_out_idx, s_out_last, s_out_zero, s_out_err, s_in_ready}, 10'b0_0000_000_1);
        chk("rst_drain",  {d_out_valid, d_out_idx, d_out_last, d_out_zero, d_out_err, d_in_ready}, 10'b0_0000_000_1);
`ifdef ONEHOT_ERR_CNT_EN
        chk("rst_err_cnt", {s_err_cnt, d_err_cnt}, 32'd0);
`endif
        rst = 1'b0;
        @(posedge clk);
        #1;

        // STRICT single bit 10
        s_q.push_back('{idx: 4'd10, last: 1'b1, zero: 1'b0, err: 1'b0});
        send_s(16'h0400);
        @(negedge clk);
        chk("t1_latency", s_out_valid, 1);
        @(posedge clk);
        #1;

        // STRICT two bits: lowest wins, err flagged
        s_q.push_back('{idx: 4'd4, last: 1'b1, zero: 1'b0, err: 1'b1});
        send_s(16'h8010);
`ifdef ONEHOT_ERR_CNT_EN
        chk("t2_err_cnt_before", s_err_cnt, 0);
`endif
        @(posedge clk);
        #1;
`ifdef ONEHOT_ERR_CNT_EN
        chk("t2_err_cnt_after", s_err_cnt, 1);
`endif
        chk("t2_idle", s_out_valid, 0);

        // DRAIN 0x8025 -> 0,2,5,15
        d_q.push_back('{idx: 4'd0,  last: 1'b0, zero: 1'b0, err: 1'b0});
        d_q.push_back('{idx: 4'd2,  last: 1'b0, zero: 1'b0, err: 1'b0});
        d_q.push_back('{idx: 4'd5,  last: 1'b0, zero: 1'b0, err: 1'b0});
        d_q.push_back('{idx: 4'd15, last: 1'b1, zero: 1'b0, err: 1'b0});
        send_d(16'h8025);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk("t3_valid_in_ready", {d_out_valid, d_in_ready}, {1'b1, (k == 4)});
        end
        @(posedge clk);
        #1;
        chk("t3_done", {d_out_valid, (d_q.size() == 0)}, 2'b01);

        // DRAIN 0x0003 with downstream stalled
        d_out_ready = 1'b0;
        d_q.push_back('{idx: 4'd0, last: 1'b0, zero: 1'b0, err: 1'b0});
        d_q.push_back('{idx: 4'd1, last: 1'b1, zero: 1'b0, err: 1'b0});
        send_d(16'h0003);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t4_hold", {d_out_valid, d_out_idx, d_in_ready}, {1'b1, 4'd0, 1'b0});
        end
        @(posedge clk);
        #1;
        d_out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("t4_done", {d_out_valid, (d_q.size() == 0)}, 2'b01);

        // STRICT back-to-back zero vectors
        for (int k = 0; k < 3; k++) s_q.push_back('{idx: 4'd0, last: 1'b1, zero: 1'b1, err: 1'b0});
        t0 = $time;
        send_s(16'h0000);
        send_s(16'h0000);
        send_s(16'h0000);
        chk("t5_no_bubble", 32'($time - t0), 32'd30);
        @(posedge clk);
        #1;
        chk("t5_done", {s_out_valid, (s_q.size() == 0)}, 2'b01);
`ifdef ONEHOT_ERR_CNT_EN
        chk("t5_err_cnt", s_err_cnt, 4);
`endif

        // DRAIN zero vector
        d_q.push_back('{idx: 4'd0, last: 1'b1, zero: 1'b1, err: 1'b0});
        send_d(16'h0000);
        @(posedge clk);
        #1;
        chk("t5_drain_zero_done", {d_out_valid, (d_q.size() == 0)}, 2'b01);
`ifdef ONEHOT_ERR_CNT_EN
        chk("t5_drain_err_cnt", d_err_cnt, 1);
`endif

        // DRAIN 0xFFFF interrupted by async reset after the third beat
        d_q.push_back('{idx: 4'd0, last: 1'b0, zero: 1'b0, err: 1'b0});
        d_q.push_back('{idx: 4'd1, last: 1'b0, zero: 1'b0, err: 1'b0});
        d_q.push_back('{idx: 4'd2, last: 1'b0, zero: 1'b0, err: 1'b0});
        send_d(16'hFFFF);
        repeat (3) @(posedge clk);
        #2;
        chk("t6_pre_rst_idx", {d_out_valid, d_out_idx}, {1'b1, 4'd3});
        rst = 1'b1;
        #1;
        chk("t6_rst_async", {d_out_valid, d_out_idx, d_out_last, d_in_ready}, {1'b0, 4'd0, 1'b0, 1'b1});
        chk("t6_q_empty", d_q.size(), 0);
`ifdef ONEHOT_ERR_CNT_EN
        chk("t6_err_cnt_clr", d_err_cnt, 0);
`endif
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("t6_no_partial", d_out_valid, 0);
        d_q.push_back('{idx: 4'd8, last: 1'b1, zero: 1'b0, err: 1'b0});
        send_d(16'h0100);
        @(posedge clk);
        #1;
        chk("t6_after_rst", {d_out_valid, (d_q.size() == 0)}, 2'b01);

        repeat (2) @(posedge clk);
        #1;
        chk("final_queues_empty", {(s_q.size() == 0), (d_q.size() == 0)}, 2'b11);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_multihot_to_bin_seq
`default_nettype wire
